// File: rtl/regbank_alu_seq.sv
// Multi-cycle ALU sequencer in front of a 4x32 register bank.
// Each accepted instruction runs through READ -> EXEC -> WB, one instruction every 4 cycles.
module regbank_alu_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] rb_sr1,
    output logic [ADDR_W-1:0] rb_sr2,
    input  logic [DATA_W-1:0] rb_rdData1,
    input  logic [DATA_W-1:0] rb_rdData2,
    output logic              rb_write,
    output logic [ADDR_W-1:0] rb_dr,
    output logic [DATA_W-1:0] rb_wrData,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        op_p0;
    logic [ADDR_W-1:0] dst_p0;
    logic [DATA_W-1:0] opa_p1;
    logic [DATA_W-1:0] opb_p1;
    logic [DATA_W:0]   res_p2;
    logic              accept;

    // Bit DATA_W carries ADD carry-out or SUB borrow; it is zero for every other op.
    function automatic logic [DATA_W:0] alu_exec(input logic [2:0] f,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        case (f)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} - {1'b0, b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {1'b0, a};
            3'b110:  r = {1'b0, ~a};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    assign accept = instr_valid && instr_ready;

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = S_READ;
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A reset arriving during WB suppresses the write so an aborted instruction never commits.
    assign rb_write  = (state == S_WB) && !rst;
    assign done      = rb_write;
    assign rb_wrData = res_p2[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rb_sr1 <= '0;
            rb_sr2 <= '0;
            rb_dr  <= '0;
            res_p2 <= '0;
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            state <= state_nxt;
            // stage 0: accept, read addresses stay on the bank until the next accept
            if (accept) begin
                rb_sr1 <= src_a;
                rb_sr2 <= src_b;
            end
            // stage 2: execute into the write-back register
            if (state == S_EXEC) begin
                res_p2 <= alu_exec(op_p0, opa_p1, opb_p1);
                rb_dr  <= dst_p0;
            end
            // stage 3: write-back, architectural result and flags
            if (state == S_WB) begin
                result <= res_p2[DATA_W-1:0];
                flag_z <= (res_p2[DATA_W-1:0] == '0);
                flag_c <= res_p2[DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= op;
            dst_p0 <= dst;
        end
        // stage 1: operand capture, so dst may alias either source
        if (state == S_READ) begin
            opa_p1 <= rb_rdData1;
            opb_p1 <= rb_rdData2;
        end
    end

endmodule

// File: tb/tb_regbank_alu_seq.sv
// Bench for regbank_alu_seq: behavioural register bank plus an instruction-level reference model.
module tb_regbank_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [1:0]  src_a, src_b, dst;
    logic [1:0]  rb_sr1, rb_sr2, rb_dr;
    logic [31:0] rb_rdData1, rb_rdData2, rb_wrData;
    logic        rb_write, done;
    logic [31:0] result;
    logic        flag_z, flag_c;

    always #5 clk = ~clk;

    regbank_alu_seq #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
        .rb_sr1(rb_sr1), .rb_sr2(rb_sr2),
        .rb_rdData1(rb_rdData1), .rb_rdData2(rb_rdData2),
        .rb_write(rb_write), .rb_dr(rb_dr), .rb_wrData(rb_wrData),
        .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
    );

    // Register bank: combinational reads, synchronous write; pre_we is a bench-only preload port.
    logic [31:0] bank [4];
    logic        pre_we = 1'b0;
    logic [1:0]  pre_a  = 2'd0;
    logic [31:0] pre_d  = 32'd0;

    assign rb_rdData1 = bank[rb_sr1];
    assign rb_rdData2 = bank[rb_sr2];

    always @(posedge clk) begin
        if (rb_write) bank[rb_dr] <= rb_wrData;
        else if (pre_we) bank[pre_a] <= pre_d;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] mbank [4];
    logic [31:0] mres;
    logic        mz, mc;
    int          total = 0;
    int          bad = 0;
    int          acc_cyc = -100;
    int          prev_acc = -100;

    task automatic preload(input int i, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = i[1:0];
        pre_d  = v;
        @(negedge clk);
        pre_we = 1'b0;
        mbank[i] = v;
    endtask

    task automatic preload_std();
        preload(0, 32'd0);
        preload(1, 32'd5);
        preload(2, 32'd10);
        preload(3, 32'd15);
    endtask

    // Issues one instruction and follows it to write-back; starts and ends on a negedge.
    task automatic run_instr(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] d, input bit busy_junk, input string tag);
        int k;
        bit got;
        logic [31:0] va, vb, r;
        logic c;
        longint unsigned s;
        k = 0;
        while (!instr_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_timeout: ready=%b required=1", tag, instr_ready);
            return;
        end
        va = mbank[a];
        vb = mbank[b];
        c  = 1'b0;
        case (o)
            3'd0: begin
                s = longint'(va) + longint'(vb);
                r = va + vb;
                c = (s > 64'h0000_0000_FFFF_FFFF);
            end
            3'd1: begin r = va - vb; c = (va < vb); end
            3'd2: r = va & vb;
            3'd3: r = va | vb;
            3'd4: r = va ^ vb;
            3'd5: r = va;
            3'd6: r = ~va;
            default: r = vb;
        endcase
        instr_valid = 1'b1;
        op = o; src_a = a; src_b = b; dst = d;
        @(posedge clk);
        #1;
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        instr_valid = busy_junk;
        op = 3'($urandom); src_a = 2'($urandom); src_b = 2'($urandom); dst = 2'($urandom);
        got = 1'b0;
        for (k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (rb_sr1 !== a || rb_sr2 !== b) begin
                    bad++;
                    $display("FAIL %s read_addr: sr1=%0d sr2=%0d required %0d %0d", tag, rb_sr1, rb_sr2, a, b);
                end
            end
            if (rb_write === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy_junk) begin
                op = 3'($urandom); src_a = 2'($urandom); src_b = 2'($urandom); dst = 2'($urandom);
            end
        end
        instr_valid = 1'b0;
        total++;
        if (!got || k != 3) begin
            bad++;
            $display("FAIL %s latency: write_after=%0d got=%0d required=3", tag, k, got);
        end
        if (got) begin
            total++;
            if (rb_dr !== d || rb_wrData !== r || done !== 1'b1) begin
                bad++;
                $display("FAIL %s wb_port: dr=%0d data=%h done=%b required dr=%0d data=%h done=1",
                         tag, rb_dr, rb_wrData, done, d, r);
            end
        end
        @(posedge clk);
        mbank[d] = r;
        mres = r;
        mz = (r == 32'd0);
        mc = c;
        @(negedge clk);
        total++;
        if (bank[0] !== mbank[0] || bank[1] !== mbank[1] || bank[2] !== mbank[2] || bank[3] !== mbank[3]) begin
            bad++;
            $display("FAIL %s bank: %h %h %h %h required %h %h %h %h", tag, bank[0], bank[1], bank[2], bank[3],
                     mbank[0], mbank[1], mbank[2], mbank[3]);
        end
        total++;
        if (result !== mres || flag_z !== mz || flag_c !== mc || rb_write !== 1'b0 || instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s post_wb: result=%h z=%b c=%b wr=%b rdy=%b required result=%h z=%b c=%b wr=0 rdy=1",
                     tag, result, flag_z, flag_c, rb_write, instr_ready, mres, mz, mc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        op = 3'd0; src_a = 2'd0; src_b = 2'd0; dst = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (instr_ready !== 1'b1 || rb_write !== 1'b0 || done !== 1'b0 || result !== 32'd0 ||
            flag_z !== 1'b0 || flag_c !== 1'b0 || rb_sr1 !== 2'd0 || rb_sr2 !== 2'd0 ||
            rb_dr !== 2'd0 || rb_wrData !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b wr=%b done=%b res=%h z=%b c=%b sr=%0d/%0d dr=%0d wd=%h required rdy=1 rest 0",
                     instr_ready, rb_write, done, result, flag_z, flag_c, rb_sr1, rb_sr2, rb_dr, rb_wrData);
        end
        mres = 32'd0; mz = 1'b0; mc = 1'b0;
        preload_std();
    endtask

    task automatic test_directed();
        run_instr(3'd0, 2'd1, 2'd2, 2'd3, 1'b0, "add_basic");
        total++;
        if (bank[3] !== 32'd15 || result !== 32'd15 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL add_const: r3=%h res=%h z=%b c=%b required 15 15 0 0", bank[3], result, flag_z, flag_c);
        end
        run_instr(3'd1, 2'd1, 2'd2, 2'd0, 1'b0, "sub_borrow");
        total++;
        if (bank[0] !== 32'hFFFF_FFFB || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            bad++;
            $display("FAIL sub_const: r0=%h c=%b z=%b required fffffffb 1 0", bank[0], flag_c, flag_z);
        end
        run_instr(3'd4, 2'd2, 2'd2, 2'd1, 1'b0, "xor_zero");
        total++;
        if (bank[1] !== 32'd0 || flag_z !== 1'b1) begin
            bad++;
            $display("FAIL xor_const: r1=%h z=%b required 0 1", bank[1], flag_z);
        end
    endtask

    task automatic test_back_to_back();
        preload_std();
        run_instr(3'd0, 2'd1, 2'd1, 2'd2, 1'b0, "b2b_add");
        run_instr(3'd5, 2'd2, 2'd0, 2'd3, 1'b0, "b2b_mov");
        total++;
        if (bank[3] !== 32'd10 || acc_cyc - prev_acc != 4) begin
            bad++;
            $display("FAIL b2b: r3=%h accept_gap=%0d required r3=a gap=4", bank[3], acc_cyc - prev_acc);
        end
    endtask

    task automatic test_carry_wrap();
        preload(3, 32'hFFFF_FFFF);
        preload(1, 32'd1);
        run_instr(3'd0, 2'd3, 2'd1, 2'd0, 1'b0, "add_wrap");
        total++;
        if (bank[0] !== 32'd0 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            bad++;
            $display("FAIL wrap_const: r0=%h c=%b z=%b required 0 1 1", bank[0], flag_c, flag_z);
        end
    endtask

    task automatic test_abort();
        int k;
        bit wrote;
        preload_std();
        run_instr(3'd2, 2'd2, 2'd3, 2'd1, 1'b0, "pre_abort");
        instr_valid = 1'b1;
        op = 3'd0; src_a = 2'd1; src_b = 2'd2; dst = 2'd3;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mres = 32'd0; mz = 1'b0; mc = 1'b0;
        total++;
        if (instr_ready !== 1'b1 || rb_write !== 1'b0 || done !== 1'b0 || result !== 32'd0 ||
            flag_z !== 1'b0 || flag_c !== 1'b0 || rb_sr1 !== 2'd0 || rb_sr2 !== 2'd0 ||
            rb_dr !== 2'd0 || rb_wrData !== 32'd0) begin
            bad++;
            $display("FAIL abort_state: rdy=%b wr=%b res=%h z=%b c=%b sr=%0d/%0d dr=%0d wd=%h required rdy=1 rest 0",
                     instr_ready, rb_write, result, flag_z, flag_c, rb_sr1, rb_sr2, rb_dr, rb_wrData);
        end
        wrote = 1'b0;
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rb_write !== 1'b0) wrote = 1'b1;
        end
        total++;
        if (wrote || bank[3] !== mbank[3]) begin
            bad++;
            $display("FAIL abort_nowrite: wrote=%b r3=%h required wrote=0 r3=%h", wrote, bank[3], mbank[3]);
        end
    endtask

    task automatic test_busy_ignored();
        for (int i = 0; i < 6; i++)
            run_instr(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'b1, "busy_junk");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) preload($urandom_range(0, 3), $urandom);
            run_instr(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'b0, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_carry_wrap();
        test_abort();
        test_busy_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
